rv32imf_fpu_wb_buffer: RTL and testbench

Receive-side counterpart of the FPU operation issue interface. Accepts completed results from the FPU (result, status flags, operation class, destination tag) through a valid/ready handshake and buffers them in order. Presents them to the core writeback stage, steering each result to the integer or FP register file according to its operation class. Maintains the sticky fflags accumulator that feeds the fcsr.

---
 rtl/rv32imf_fpu_wb_buffer_pkg.sv | 55 +++++
 rtl/rv32imf_fpu_wb_fifo.sv | 65 ++++++
 rtl/rv32imf_fpu_wb_buffer.sv | 93 +++++++++
 tb/tb_rv32imf_fpu_wb_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32imf_fpu_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_fpu_wb_buffer_pkg
// Brief   : Shared types for the FPU result writeback buffer.
// Revision: 1.0 - initial release
// ============================================================================
package rv32imf_fpu_wb_buffer_pkg;

  localparam int OP_BITS    = 4;
  localparam int FPU_DATA_W = 32;
  localparam int FPU_TAG_W  = 5;

  typedef enum logic [OP_BITS-1:0] {
    ADD      = 4'd0,
    SUB      = 4'd1,
    MUL      = 4'd2,
    DIV      = 4'd3,
    SQRT     = 4'd4,
    FMADD    = 4'd5,
    FMSUB    = 4'd6,
    FNMADD   = 4'd7,
    FNMSUB   = 4'd8,
    SGNJ     = 4'd9,
    MINMAX   = 4'd10,
    CMP      = 4'd11,
    CLASSIFY = 4'd12,
    F2I      = 4'd13,
    I2F      = 4'd14
  } operation_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_status_t;

  typedef struct packed {
    logic [FPU_DATA_W-1:0] data;
    fp_status_t            status;
    logic [FPU_TAG_W-1:0]  tag;
    logic                  is_int;
  } fpu_wb_entry_t;

  // Compares, classifies and float-to-int conversions land in the integer regfile.
  function automatic logic is_int_dest(input operation_e op);
    case (op)
      CMP, CLASSIFY, F2I: is_int_dest = 1'b1;
      default:            is_int_dest = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32imf_fpu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_fpu_wb_fifo
// Brief   : Synchronous FIFO with occupancy count, flush and push+pop when full.
// Revision: 1.0 - initial release
// ============================================================================
module rv32imf_fpu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [PTR_W:0]   count_d, count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      else if (!push_i && pop_i) count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; validity is carried by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/rv32imf_fpu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_fpu_wb_buffer
// Brief   : In-order FPU result buffer with regfile steering and sticky fflags.
// Revision: 1.0 - initial release
// ============================================================================
module rv32imf_fpu_wb_buffer
  import rv32imf_fpu_wb_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  input  logic [DATA_W-1:0]        fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic [OP_BITS-1:0]       fpu_op_i,
  input  logic [TAG_W-1:0]         fpu_tag_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic [TAG_W-1:0]         wb_rd_o,
  output logic                     wb_is_int_o,
  output logic [4:0]               wb_fflags_o,
  input  logic                     flush_i,
  input  logic                     fflags_clr_i,
  output logic [4:0]               fflags_acc_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + 5 + TAG_W + 1;

  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [DATA_W-1:0]  head_data;
  fp_status_t         head_status;
  logic [TAG_W-1:0]   head_tag;
  logic               head_is_int;
  logic [4:0]         acc_d, acc_q;

  assign wb_valid_o  = (count != '0);
  assign pop         = wb_valid_o && wb_ready_i;
  assign fpu_ready_o = !flush_i && ((count < CNT_W'(DEPTH)) || pop);
  assign push        = fpu_valid_i && fpu_ready_o;

  assign wr_entry = {fpu_result_i, fpu_status_i, fpu_tag_i,
                     is_int_dest(operation_e'(fpu_op_i))};

  rv32imf_fpu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (count)
  );

  assign {head_data, head_status, head_tag, head_is_int} = rd_entry;

  // Stale storage must never leak onto the writeback bus.
  assign wb_data_o   = wb_valid_o ? head_data   : '0;
  assign wb_rd_o     = wb_valid_o ? head_tag    : '0;
  assign wb_is_int_o = wb_valid_o ? head_is_int : 1'b0;
  assign wb_fflags_o = wb_valid_o ? head_status : '0;

  always_comb begin
    acc_d = acc_q;
    if (fflags_clr_i) acc_d = pop ? wb_fflags_o : 5'b0;
    else if (pop)     acc_d = acc_q | wb_fflags_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign fflags_acc_o = acc_q;
  assign occupancy_o  = count;

endmodule
`default_nettype wire

// File: tb/tb_rv32imf_fpu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32imf_fpu_wb_buffer
// Brief   : Directed vector table plus randomized run against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32imf_fpu_wb_buffer;
  import rv32imf_fpu_wb_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i, fpu_valid_i, wb_ready_i, flush_i, fflags_clr_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i, fpu_tag_i;
  logic [3:0]  fpu_op_i;
  logic        fpu_ready_o, wb_valid_o, wb_is_int_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o, wb_fflags_o, fflags_acc_o;
  logic [2:0]  occupancy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32imf_fpu_wb_buffer #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_op_i(fpu_op_i), .fpu_tag_i(fpu_tag_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_is_int_o(wb_is_int_o), .wb_fflags_o(wb_fflags_o),
    .flush_i(flush_i), .fflags_clr_i(fflags_clr_i),
    .fflags_acc_o(fflags_acc_o), .occupancy_o(occupancy_o)
  );

  typedef struct {
    logic rst, vld, wrdy, flush, clr;
    logic [3:0] op; logic [31:0] data; logic [4:0] st; logic [4:0] tag;
    logic e_rdy, e_v; logic [31:0] e_d; logic [4:0] e_rd; logic e_int;
    logic [4:0] e_fl; logic [2:0] e_occ; logic [4:0] e_acc;
  } vec_t;

  typedef struct {
    logic [31:0] d; logic [4:0] fl; logic [4:0] tag; logic is_int;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic [4:0] macc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic rst, vld, wrdy, flush, clr, input logic [3:0] op,
                     input logic [31:0] data, input logic [4:0] st, tag,
                     input logic e_rdy, e_v, input logic [31:0] e_d, input logic [4:0] e_rd,
                     input logic e_int, input logic [4:0] e_fl, input logic [2:0] e_occ,
                     input logic [4:0] e_acc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wrdy = wrdy; v.flush = flush; v.clr = clr;
    v.op = op; v.data = data; v.st = st; v.tag = tag;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_rd = e_rd; v.e_int = e_int;
    v.e_fl = e_fl; v.e_occ = e_occ; v.e_acc = e_acc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, vld, wrdy, flush, clr, input logic [3:0] op,
                       input logic [31:0] data, input logic [4:0] st, tag);
    rst_i = rst; fpu_valid_i = vld; wb_ready_i = wrdy; flush_i = flush;
    fflags_clr_i = clr; fpu_op_i = op; fpu_result_i = data;
    fpu_status_i = st; fpu_tag_i = tag;
  endtask

  initial begin
    vec_t v;
    ent_t h, e;
    logic r_rst, r_vld, r_wrdy, r_fl, r_clr, has, e_pop, e_rdy, e_push;
    logic [3:0] r_op;
    logic [31:0] r_d;
    logic [4:0] r_st, r_tag;

    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,0);
    row(0,1,0,0,0, ADD,32'h3F800000,5'b00001,3, 1,0,0,0,0,0,0,0);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,32'h3F800000,3,0,5'b00001,1,0);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00001);
    row(0,1,0,0,0, CMP,1,0,10,                  1,0,0,0,0,0,0,5'b00001);
    row(0,1,0,0,0, F2I,2,0,11,                  1,1,1,10,1,0,1,5'b00001);
    row(0,1,0,0,0, MUL,32'h40000000,5'b00010,12,1,1,1,10,1,0,2,5'b00001);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,1,10,1,0,3,5'b00001);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,2,11,1,0,2,5'b00001);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,32'h40000000,12,0,5'b00010,1,5'b00001);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00011);
    for (int i = 0; i < 4; i++)
      row(0,1,0,0,0, ADD,32'hA0+i,0,5'(20+i), 1,(i!=0),(i!=0)?32'hA0:0,(i!=0)?5'd20:5'd0,0,0,3'(i),5'b00011);
    row(0,1,0,0,0, ADD,32'hA4,0,24,             0,1,32'hA0,20,0,0,4,5'b00011);
    for (int i = 0; i < 4; i++)
      row(0,1,1,0,0, ADD,32'hA4+i,0,5'(24+i), 1,1,32'hA0+i,5'(20+i),0,0,4,5'b00011);
    for (int i = 0; i < 4; i++)
      row(0,0,1,0,0, ADD,0,0,0, 1,1,32'hA4+i,5'(24+i),0,0,3'(4-i),5'b00011);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00011);
    for (int i = 0; i < 3; i++)
      row(0,1,0,0,0, ADD,32'hB0+i,0,5'(1+i), 1,(i!=0),(i!=0)?32'hB0:0,(i!=0)?5'd1:5'd0,0,0,3'(i),5'b00011);
    row(0,1,0,1,0, ADD,32'hB3,0,4,              0,1,32'hB0,1,0,0,3,5'b00011);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00011);
    row(0,0,0,0,1, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00011);
    row(0,1,0,0,0, ADD,32'hC0,5'b10000,4,       1,0,0,0,0,0,0,0);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,32'hC0,4,0,5'b10000,1,0);
    row(0,1,0,0,0, ADD,32'hC1,5'b00100,5,       1,0,0,0,0,0,0,5'b10000);
    row(0,0,1,0,1, ADD,0,0,0,                   1,1,32'hC1,5,0,5'b00100,1,5'b10000);
    row(0,0,0,0,1, ADD,0,0,0,                   1,0,0,0,0,0,0,5'b00100);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,0);
    row(0,1,0,0,0, ADD,32'hD0,5'b00011,6,       1,0,0,0,0,0,0,0);
    row(0,0,1,0,0, ADD,0,0,0,                   1,1,32'hD0,6,0,5'b00011,1,0);
    row(0,1,0,0,0, ADD,32'hD1,0,7,              1,0,0,0,0,0,0,5'b00011);
    row(0,1,0,0,0, ADD,32'hD2,0,8,              1,1,32'hD1,7,0,0,1,5'b00011);
    row(1,0,0,0,0, ADD,0,0,0,                   1,1,32'hD1,7,0,0,2,5'b00011);
    row(0,0,0,0,0, ADD,0,0,0,                   1,0,0,0,0,0,0,0);

    drive(1,0,0,0,0, ADD,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.rst, v.vld, v.wrdy, v.flush, v.clr, v.op, v.data, v.st, v.tag);
      @(negedge clk);
      check($sformatf("row%0d ready", i),  32'(fpu_ready_o),  32'(v.e_rdy));
      check($sformatf("row%0d valid", i),  32'(wb_valid_o),   32'(v.e_v));
      check($sformatf("row%0d data", i),   wb_data_o,         v.e_d);
      check($sformatf("row%0d rd", i),     32'(wb_rd_o),      32'(v.e_rd));
      check($sformatf("row%0d is_int", i), 32'(wb_is_int_o),  32'(v.e_int));
      check($sformatf("row%0d fflags", i), 32'(wb_fflags_o),  32'(v.e_fl));
      check($sformatf("row%0d occ", i),    32'(occupancy_o),  32'(v.e_occ));
      check($sformatf("row%0d acc", i),    32'(fflags_acc_o), 32'(v.e_acc));
      @(posedge clk);
      #1;
    end

    drive(1,0,0,0,0, ADD,0,0,0);
    @(posedge clk);
    #1;
    mq.delete();
    macc = '0;
    for (int c = 0; c < 600; c++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_vld  = ($urandom_range(0, 9) < 7);
      r_wrdy = ($urandom_range(0, 9) < 5);
      r_fl   = ($urandom_range(0, 39) == 0);
      r_clr  = ($urandom_range(0, 19) == 0);
      r_op   = 4'($urandom_range(0, 14));
      r_d    = $urandom;
      r_st   = 5'($urandom);
      r_tag  = 5'($urandom);
      drive(r_rst, r_vld, r_wrdy, r_fl, r_clr, r_op, r_d, r_st, r_tag);
      @(negedge clk);

      has = (mq.size() != 0);
      h = '{d: 0, fl: 0, tag: 0, is_int: 0};
      if (has) h = mq[0];
      e_pop  = has && r_wrdy;
      e_rdy  = !r_fl && ((mq.size() < DEPTH) || e_pop);
      e_push = r_vld && e_rdy;
      check($sformatf("rnd%0d ready", c),  32'(fpu_ready_o),  32'(e_rdy));
      check($sformatf("rnd%0d valid", c),  32'(wb_valid_o),   32'(has));
      check($sformatf("rnd%0d data", c),   wb_data_o,         h.d);
      check($sformatf("rnd%0d rd", c),     32'(wb_rd_o),      32'(h.tag));
      check($sformatf("rnd%0d is_int", c), 32'(wb_is_int_o),  32'(h.is_int));
      check($sformatf("rnd%0d fflags", c), 32'(wb_fflags_o),  32'(h.fl));
      check($sformatf("rnd%0d occ", c),    32'(occupancy_o),  32'(mq.size()));
      check($sformatf("rnd%0d acc", c),    32'(fflags_acc_o), 32'(macc));

      if (r_clr)      macc = e_pop ? h.fl : 5'b0;
      else if (e_pop) macc = macc | h.fl;
      if (e_pop) void'(mq.pop_front());
      if (r_fl) mq.delete();
      else if (e_push) begin
        e.d = r_d; e.fl = r_st; e.tag = r_tag;
        e.is_int = (r_op inside {CMP, CLASSIFY, F2I});
        mq.push_back(e);
      end
      if (r_rst) begin
        mq.delete();
        macc = '0;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
